// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the MSB-first, start-framed serial link. The
// transmitter and the receiver (serial_in) both use them.
//
// Contents:
//   state_t    - receiver state encoding (ST_IDLE, ST_RECV, ST_PAR)
//   SER_WIDTH  - default frame width in data bits
//   cnt_width  - bit-counter width for a given frame width
//   CNT_W      - bit-counter width for the default frame width
//
// Configuration macro (used by serial_in): SERIAL_IN_PARITY_EN
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam int SER_WIDTH = 16;

    // The counter only ever holds WIDTH-2 down to 0, so clog2(WIDTH) bits are
    // always enough. The floor of 1 keeps the width legal for tiny frames.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(SER_WIDTH);

endpackage

// File: rtl/serial_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
// Left shift register with a shift enable and a parallel output. When en is
// high, d enters at the LSB and the existing contents move one place toward
// the MSB.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset; clears the register
//   en   in   shift enable
//   d    in   serial bit shifted into the LSB
//   q    out  [WIDTH-1:0] parallel register contents
// -----------------------------------------------------------------------------
module serial_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Shift on every enabled edge. The contents are held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], d};
        end
    end

endmodule

// File: rtl/serial_in.sv
// -----------------------------------------------------------------------------
// serial_in
// Serial-to-parallel receiver for the MSB-first, start-framed serial link.
// The edge on which start is high carries the MSB. The next WIDTH-1 edges
// carry the remaining bits. The completed word appears on dout together with a
// one-cycle valid pulse. If start is seen while a frame is still arriving, that
// frame is aborted and reception restarts with the new MSB.
//
// Optional feature: `define SERIAL_IN_PARITY_EN
//   When this macro is defined, one even-parity bit follows bit 0. dout, perr
//   and valid update after the parity edge. When it is not defined, perr is
//   tied to 0.
//
// Ports:
//   clk    in   system clock; all sampling happens on the rising edge
//   rst    in   asynchronous active-high reset
//   start  in   frame start qualifier; high on the edge that carries the MSB
//   D      in   serial data, MSB first
//   dout   out  [WIDTH-1:0] last completed word; held until the next completion
//   valid  out  one-cycle pulse marking a dout update
//   busy   out  high while a frame is being received
//   perr   out  parity error; only meaningful while valid is high
// -----------------------------------------------------------------------------
module serial_in
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             D,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             perr
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             shift_en;

    // A start edge always shifts, because it also restarts an aborted frame.
    // Data bits shift only in RECV. D is ignored in IDLE and on the parity edge.
    assign shift_en = start || (state == ST_RECV);

    serial_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   (D),
        .q   (shreg)
    );

`ifdef SERIAL_IN_PARITY_EN

    logic par_acc;

    // The full word is already in shreg when the parity edge arrives, so dout
    // loads straight from it. An even-parity mismatch is flagged, but the word
    // is delivered anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            perr    <= 1'b0;
            par_acc <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                state   <= ST_RECV;
                cnt     <= CW'(WIDTH - 2);
                busy    <= 1'b1;
                par_acc <= D;
            end else begin
                case (state)
                    ST_RECV: begin
                        par_acc <= par_acc ^ D;
                        if (cnt == '0) begin
                            state <= ST_PAR;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_PAR: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        dout  <= shreg;
                        perr  <= par_acc ^ D;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`else

    logic [WIDTH-1:0] word;
    logic             unused_msb;

    // On the edge that captures bit 0, the completed word is the shift
    // register's next value. The old MSB falls off the top at that point.
    assign word       = {shreg[WIDTH-2:0], D};
    assign unused_msb = shreg[WIDTH-1];
    assign perr       = 1'b0;

    // A start always (re)loads the counter. Frame completion returns to IDLE,
    // so a start on the very next edge begins a new frame with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dout  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                state <= ST_RECV;
                cnt   <= CW'(WIDTH - 2);
                busy  <= 1'b1;
            end else begin
                case (state)
                    ST_RECV: begin
                        if (cnt == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            dout  <= word;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`endif

endmodule

// File: tb/tb_serial_in.sv
// -----------------------------------------------------------------------------
// tb_serial_in
// Directed testbench for serial_in with WIDTH=16. A table of frames is
// serialised MSB first, and every cycle of each frame is checked against
// hand-computed busy/valid/dout/perr values. Hand-written sequences then cover
// restart, asynchronous reset, a random loopback run and, when
// SERIAL_IN_PARITY_EN is defined, the parity cases.
// -----------------------------------------------------------------------------
module tb_serial_in;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         D;
    logic [W-1:0] dout;
    logic         valid;
    logic         busy;
    logic         perr;

    int checkCount = 0;
    int passCount  = 0;

    // The bench's own record of what dout should currently hold.
    logic [W-1:0] lastDout = '0;

    typedef struct {
        logic [W-1:0] word;
        logic         parBit;
        int           gap;
        logic [W-1:0] expDout;
        logic         expPerr;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    serial_in #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .D     (D),
        .dout  (dout),
        .valid (valid),
        .busy  (busy),
        .perr  (perr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive inputs at the falling edge, let the DUT sample them, and then
    // return 1 time unit after the rising edge so the outputs can be checked.
    task automatic applyStimulus(input logic s, input logic d);
        @(negedge clk);
        start = s;
        D     = d;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with D toggling. D must be ignored here.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, k[0]);
            checkOutput("idle_valid", {31'd0, valid}, 32'd0);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_dout", {16'd0, dout}, {16'd0, lastDout});
        end
    endtask

    // Send the top nBits bits of a word, starting with the MSB. The frame
    // stays incomplete, so no valid may appear.
    task automatic sendPartial(input logic [W-1:0] word, input int nBits);
        for (int i = W - 1; i >= W - nBits; i--) begin
            applyStimulus(i == W - 1, word[i]);
            checkOutput("part_busy", {31'd0, busy}, 32'd1);
            checkOutput("part_valid", {31'd0, valid}, 32'd0);
            checkOutput("part_dout", {16'd0, dout}, {16'd0, lastDout});
        end
    endtask

    task automatic sendFrame(input logic [W-1:0] word, input logic parBit,
                             input logic [W-1:0] expDout, input logic expPerr);
        for (int i = W - 1; i >= 1; i--) begin
            applyStimulus(i == W - 1, word[i]);
            checkOutput("mid_busy", {31'd0, busy}, 32'd1);
            checkOutput("mid_valid", {31'd0, valid}, 32'd0);
            checkOutput("mid_dout", {16'd0, dout}, {16'd0, lastDout});
        end
        applyStimulus(1'b0, word[0]);
`ifdef SERIAL_IN_PARITY_EN
        checkOutput("prepar_valid", {31'd0, valid}, 32'd0);
        checkOutput("prepar_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, parBit);
`else
        if (parBit !== 1'b0 && parBit !== 1'b1) begin
            $display("[TB] note: parity bit is unknown and is ignored in this build");
        end
`endif
        checkOutput("done_valid", {31'd0, valid}, 32'd1);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
        checkOutput("done_dout", {16'd0, dout}, {16'd0, expDout});
        checkOutput("done_perr", {31'd0, perr}, {31'd0, expPerr});
        lastDout = expDout;
    endtask

    initial begin
        logic [W-1:0] w;
        logic         p;

        // A gap of 0 makes the next frame start on the edge right after the
        // previous LSB, which gives back-to-back frames.
        vecs[0] = '{word: 16'hA5C3, parBit: 1'b0, gap: 2, expDout: 16'hA5C3, expPerr: 1'b0};
        vecs[1] = '{word: 16'h1234, parBit: 1'b1, gap: 0, expDout: 16'h1234, expPerr: 1'b0};
        vecs[2] = '{word: 16'hFFFF, parBit: 1'b0, gap: 3, expDout: 16'hFFFF, expPerr: 1'b0};
        vecs[3] = '{word: 16'h0000, parBit: 1'b0, gap: 0, expDout: 16'h0000, expPerr: 1'b0};
        vecs[4] = '{word: 16'h8001, parBit: 1'b0, gap: 1, expDout: 16'h8001, expPerr: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        D     = 1'b0;
        #12;
        checkOutput("rst_dout", {16'd0, dout}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_perr", {31'd0, perr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        idleCycles(3);

        for (int v = 0; v < 5; v++) begin
            sendFrame(vecs[v].word, vecs[v].parBit, vecs[v].expDout, vecs[v].expPerr);
            idleCycles(vecs[v].gap);
        end

        // Restart: 0x0F0F is cut off after 7 bits by a fresh start.
        $display("[TB] restart sequence");
        sendPartial(16'h0F0F, 7);
        sendFrame(16'h8001, 1'b0, 16'h8001, 1'b0);
        idleCycles(2);

        // Asynchronous reset partway through 0xBEEF, applied between edges.
        $display("[TB] async reset sequence");
        sendPartial(16'hBEEF, 9);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_dout", {16'd0, dout}, 32'd0);
        checkOutput("arst_valid", {31'd0, valid}, 32'd0);
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_perr", {31'd0, perr}, 32'd0);
        lastDout = '0;
        @(negedge clk);
        rst = 1'b0;
        idleCycles(3);
        sendFrame(16'h0042, 1'b0, 16'h0042, 1'b0);
        idleCycles(1);

        // Loopback: 16 random words sent back to back with correct even parity.
        $display("[TB] loopback sequence");
        for (int n = 0; n < 16; n++) begin
            w = W'($urandom);
            p = ^w;
            sendFrame(w, p, w, 1'b0);
        end
        idleCycles(2);

`ifdef SERIAL_IN_PARITY_EN
        $display("[TB] parity sequence");
        sendFrame(16'h0003, 1'b0, 16'h0003, 1'b0);
        idleCycles(1);
        sendFrame(16'h0003, 1'b1, 16'h0003, 1'b1);
        idleCycles(1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
